data_memory_sized: RTL and testbench

- Byte-addressed, big-endian data memory for the single-cycle MIPS datapath.
- Successor to the fixed 32-bit word memory:
  - parametrised depth and endianness
  - byte/half/word stores and loads, with sign- or zero-extension (lb/lbu/lh/lhu/lw/sb/sh/sw)
  - registered read with a valid strobe
  - sticky alignment-fault capture
- Sits between the ALU address path and the writeback mux.

---
 rtl/data_memory_sized_if.sv | 28 ++
 rtl/data_memory_sized.sv | 117 +++++++++++
 tb/tb_data_memory_sized.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sized_if.sv
// Bus between the datapath and the sized data memory: one access request per
// cycle, registered load return, and the sticky alignment-fault report.
interface data_memory_sized_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  load_unsigned;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  fault_clr;
  logic [31:0]           rdata;
  logic                  rvalid;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic                  fault_we;

  modport master (
    output req, we, size, load_unsigned, addr, wdata, fault_clr,
    input  rdata, rvalid, fault, fault_addr, fault_we
  );

  modport slave (
    input  req, we, size, load_unsigned, addr, wdata, fault_clr,
    output rdata, rvalid, fault, fault_addr, fault_we
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with byte/half/word access, configurable byte
// order, one-cycle registered loads and sticky first-fault capture.
module data_memory_sized #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter string       MEM_INIT   = "",
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  data_memory_sized_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem [DEPTH];
  logic [2:0]            nbytes_c;
  logic                  misaligned_c;
  logic                  fault_hit_c;
  logic                  load_c;
  logic                  store_c;
  logic [31:0]           raw_c;
  logic [31:0]           ext_c;

  logic [31:0]           rdata_q;
  logic                  rvalid_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] fault_addr_q;
  logic                  fault_we_q;

  // Bit lane (within the access) that holds the byte at offset k from addr.
  function automatic logic [1:0] lane_of(input logic [2:0] k, input logic [2:0] nb);
    if (BIG_ENDIAN) return 2'(nb - k - 3'd1);
    else            return 2'(k);
  endfunction

  // Access width and alignment decode
  always_comb begin
    nbytes_c     = 3'd0;
    misaligned_c = 1'b0;
    case (bus.size)
      2'b00: nbytes_c = 3'd1;
      2'b01: begin
        nbytes_c     = 3'd2;
        misaligned_c = bus.addr[0];
      end
      2'b10: begin
        nbytes_c     = 3'd4;
        misaligned_c = (bus.addr[1:0] != 2'b00);
      end
      default: begin
        nbytes_c     = 3'd0;
        misaligned_c = 1'b1;
      end
    endcase
    fault_hit_c = bus.req & misaligned_c;
    load_c      = bus.req & ~bus.we & ~misaligned_c;
    store_c     = bus.req &  bus.we & ~misaligned_c;
  end

  // Gather the addressed bytes into the low lanes, then extend.
  always_comb begin
    raw_c = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes_c)
        raw_c[{lane_of(3'(k), nbytes_c), 3'b000} +: 8] = mem[bus.addr + ADDR_WIDTH'(k)];
    end
    case (nbytes_c)
      3'd1:    ext_c = {{24{raw_c[7]  & ~bus.load_unsigned}}, raw_c[7:0]};
      3'd2:    ext_c = {{16{raw_c[15] & ~bus.load_unsigned}}, raw_c[15:0]};
      default: ext_c = raw_c;
    endcase
  end

  // Store path; the array is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (store_c) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes_c)
          mem[bus.addr + ADDR_WIDTH'(k)] <= bus.wdata[{lane_of(3'(k), nbytes_c), 3'b000} +: 8];
      end
    end
  end

  // Load return and fault capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_we_q   <= 1'b0;
    end else begin
      rvalid_q <= bus.req & ~bus.we;
      if (load_c)
        rdata_q <= ext_c;
      else if (bus.req & ~bus.we)
        rdata_q <= '0;
      // A new fault outranks a same-cycle clear; otherwise the first fault is held.
      if (fault_hit_c && (!fault_q || bus.fault_clr)) begin
        fault_q      <= 1'b1;
        fault_addr_q <= bus.addr;
        fault_we_q   <= bus.we;
      end else if (bus.fault_clr) begin
        fault_q      <= 1'b0;
        fault_addr_q <= '0;
        fault_we_q   <= 1'b0;
      end
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.fault_we   = fault_we_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Drives one big-endian and one little-endian memory with the same directed
// accesses and checks both against a byte-array model every cycle.
module tb_data_memory_sized;

  localparam int unsigned AW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  data_memory_sized_if #(.ADDR_WIDTH(AW)) bus_be ();
  data_memory_sized_if #(.ADDR_WIDTH(AW)) bus_le ();

  data_memory_sized #(.ADDR_WIDTH(AW), .MEM_INIT(""), .BIG_ENDIAN(1'b1)) dut_be (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_be)
  );

  data_memory_sized #(.ADDR_WIDTH(AW), .MEM_INIT(""), .BIG_ENDIAN(1'b0)) dut_le (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_le)
  );

  // Reference model: index 0 is big-endian, index 1 little-endian.
  logic [7:0]    mm [2][64];
  logic [31:0]   m_rdata [2];
  logic          m_rvalid = 1'b0;
  logic          m_fault  = 1'b0;
  logic [AW-1:0] m_faddr  = '0;
  logic          m_fwe    = 1'b0;

  initial begin
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 64; i++) mm[e][i] = 8'h00;
  end

  function automatic int width_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [AW-1:0] a);
    int nb;
    nb = width_of(sz);
    if (nb == 0) return 1'b1;
    return (int'(a) % nb) != 0;
  endfunction

  // Position of byte k (offset from addr) in the value, counted in bytes from the LSB.
  function automatic int pos_of(input int e, input int k, input int nb);
    return (e == 0) ? (nb - 1 - k) : k;
  endfunction

  function automatic logic [31:0] model_load(input int e, input logic [AW-1:0] a,
                                             input int nb, input logic lu);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nb; k++)
      v = v | (32'(mm[e][(int'(a) + k) % 64]) << (8 * pos_of(e, k, nb)));
    if (nb < 4 && !lu && v[8*nb-1])
      v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid   <= 1'b0;
      m_fault    <= 1'b0;
      m_faddr    <= '0;
      m_fwe      <= 1'b0;
      m_rdata[0] <= '0;
      m_rdata[1] <= '0;
    end else begin
      if (bus_be.req && is_bad(bus_be.size, bus_be.addr)) begin
        if (!m_fault || bus_be.fault_clr) begin
          m_fault <= 1'b1;
          m_faddr <= bus_be.addr;
          m_fwe   <= bus_be.we;
        end
      end else if (bus_be.fault_clr) begin
        m_fault <= 1'b0;
        m_faddr <= '0;
        m_fwe   <= 1'b0;
      end
      m_rvalid <= bus_be.req && !bus_be.we;
      if (bus_be.req && !bus_be.we)
        for (int e = 0; e < 2; e++)
          m_rdata[e] <= is_bad(bus_be.size, bus_be.addr) ? 32'h0 :
                        model_load(e, bus_be.addr, width_of(bus_be.size), bus_be.load_unsigned);
      if (bus_be.req && bus_be.we && !is_bad(bus_be.size, bus_be.addr))
        for (int e = 0; e < 2; e++)
          for (int k = 0; k < width_of(bus_be.size); k++)
            mm[e][(int'(bus_be.addr) + k) % 64] <=
              8'(bus_be.wdata >> (8 * pos_of(e, k, width_of(bus_be.size))));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    chk("be_rvalid", 32'(bus_be.rvalid), 32'(m_rvalid));
    chk("be_rdata",  bus_be.rdata,       m_rdata[0]);
    chk("be_fault",  32'(bus_be.fault),  32'(m_fault));
    chk("be_faddr",  32'(bus_be.fault_addr), 32'(m_faddr));
    chk("be_fwe",    32'(bus_be.fault_we), 32'(m_fwe));
    chk("le_rvalid", 32'(bus_le.rvalid), 32'(m_rvalid));
    chk("le_rdata",  bus_le.rdata,       m_rdata[1]);
    chk("le_fault",  32'(bus_le.fault),  32'(m_fault));
    chk("le_faddr",  32'(bus_le.fault_addr), 32'(m_faddr));
    chk("le_fwe",    32'(bus_le.fault_we), 32'(m_fwe));
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic lu,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic clr);
    bus_be.req = r;  bus_be.we = w;  bus_be.size = sz;  bus_be.load_unsigned = lu;
    bus_be.addr = a; bus_be.wdata = d; bus_be.fault_clr = clr;
    bus_le.req = r;  bus_le.we = w;  bus_le.size = sz;  bus_le.load_unsigned = lu;
    bus_le.addr = a; bus_le.wdata = d; bus_le.fault_clr = clr;
  endtask

  // One cycle of stimulus; returns just after the edge that consumed it.
  task automatic acc(input logic r, input logic w, input logic [1:0] sz, input logic lu,
                     input logic [AW-1:0] a, input logic [31:0] d, input logic clr);
    drive(r, w, sz, lu, a, d, clr);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(bus_be.rvalid), 32'h0);
    chk("rst_rdata",  bus_be.rdata,       32'h0);
    chk("rst_fault",  32'(bus_be.fault),  32'h0);
    chk("rst_faddr",  32'(bus_be.fault_addr), 32'h0);
    rst_n = 1'b1;

    // Give every byte a known value so the model is fully defined.
    for (int a = 0; a < 64; a += 4) acc(1, 1, 2'd2, 0, AW'(a), 32'h0, 0);

    // Word store, word load, signed/unsigned byte loads
    acc(1, 1, 2'd2, 0, 6'd8, 32'hDEAD_BEEF, 0);
    chk("t1_store_rvalid", 32'(bus_be.rvalid), 32'h0);
    acc(1, 0, 2'd2, 0, 6'd8, '0, 0);
    chk("t1_lw_rvalid", 32'(bus_be.rvalid), 32'h1);
    chk("t1_lw_be", bus_be.rdata, 32'hDEAD_BEEF);
    chk("t1_lw_le", bus_le.rdata, 32'hDEAD_BEEF);
    acc(1, 0, 2'd0, 0, 6'd9, '0, 0);
    chk("t1_lb_be", bus_be.rdata, 32'hFFFF_FFAD);
    chk("t1_lb_le", bus_le.rdata, 32'hFFFF_FFBE);
    acc(1, 0, 2'd0, 1, 6'd9, '0, 0);
    chk("t1_lbu_be", bus_be.rdata, 32'h0000_00AD);
    acc(0, 0, 2'd0, 0, 6'd0, '0, 0);
    chk("idle_rvalid", 32'(bus_be.rvalid), 32'h0);
    chk("idle_hold",   bus_be.rdata, 32'h0000_00AD);

    // Half stores and loads
    acc(1, 1, 2'd1, 0, 6'd14, 32'h0000_1234, 0);
    acc(1, 0, 2'd2, 0, 6'd12, '0, 0);
    chk("t2_lw_be", bus_be.rdata, 32'h0000_1234);
    chk("t2_lw_le", bus_le.rdata, 32'h1234_0000);
    acc(1, 0, 2'd1, 0, 6'd14, '0, 0);
    chk("t2_lh_be", bus_be.rdata, 32'h0000_1234);
    acc(1, 1, 2'd1, 0, 6'd14, 32'h0000_8001, 0);
    acc(1, 0, 2'd1, 0, 6'd14, '0, 0);
    chk("t2_lh_neg_be", bus_be.rdata, 32'hFFFF_8001);
    chk("t2_lh_neg_le", bus_le.rdata, 32'hFFFF_8001);

    // Misaligned store, then misaligned load while fault is held
    acc(1, 1, 2'd2, 0, 6'd6, 32'hCAFE_F00D, 0);
    chk("t3_fault", 32'(bus_be.fault), 32'h1);
    chk("t3_faddr", 32'(bus_be.fault_addr), 32'd6);
    chk("t3_fwe",   32'(bus_be.fault_we), 32'h1);
    chk("t3_st_rvalid", 32'(bus_be.rvalid), 32'h0);
    acc(1, 0, 2'd2, 0, 6'd4, '0, 0);
    chk("t3_unchanged_lo", bus_be.rdata, 32'h0);
    acc(1, 0, 2'd2, 0, 6'd8, '0, 0);
    chk("t3_unchanged_hi", bus_be.rdata, 32'hDEAD_BEEF);
    acc(1, 0, 2'd1, 0, 6'd3, '0, 0);
    chk("t3_ld_rvalid", 32'(bus_be.rvalid), 32'h1);
    chk("t3_ld_rdata",  bus_be.rdata, 32'h0);
    chk("t3_first_wins", 32'(bus_be.fault_addr), 32'd6);

    // Clear racing a new fault, then a plain clear
    acc(1, 0, 2'd3, 0, 6'd20, '0, 1);
    chk("t4_fault", 32'(bus_be.fault), 32'h1);
    chk("t4_faddr", 32'(bus_be.fault_addr), 32'd20);
    chk("t4_fwe",   32'(bus_be.fault_we), 32'h0);
    acc(0, 0, 2'd0, 0, 6'd0, '0, 1);
    chk("t4_cleared", 32'(bus_be.fault), 32'h0);

    // Top word of memory in both byte orders
    acc(1, 1, 2'd2, 0, 6'd60, 32'h1122_3344, 0);
    acc(1, 0, 2'd2, 0, 6'd60, '0, 0);
    chk("t5_lw_be", bus_be.rdata, 32'h1122_3344);
    chk("t5_lw_le", bus_le.rdata, 32'h1122_3344);
    chk("t5_nofault", 32'(bus_be.fault), 32'h0);
    acc(1, 0, 2'd0, 1, 6'd60, '0, 0);
    chk("t5_lbu_be", bus_be.rdata, 32'h0000_0011);
    chk("t5_lbu_le", bus_le.rdata, 32'h0000_0044);

    // Asynchronous reset with a load result outstanding
    acc(1, 0, 2'd2, 0, 6'd8, '0, 0);
    chk("t6_pre_rvalid", 32'(bus_be.rvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(bus_be.rvalid), 32'h0);
    chk("t6_rst_rdata",  bus_be.rdata, 32'h0);
    chk("t6_rst_rdata_le", bus_le.rdata, 32'h0);
    #2 rst_n = 1'b1;
    acc(1, 0, 2'd2, 0, 6'd8, '0, 0);
    chk("t6_reload", bus_be.rdata, 32'hDEAD_BEEF);
    chk("t6_reload_rvalid", 32'(bus_be.rvalid), 32'h1);
    acc(0, 0, 2'd0, 0, 6'd0, '0, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
